// File: rtl/parser_port_arbiter.sv
// Packet-granular round-robin arbiter that shares one header-parser datapath between the
// N3 (GTP-U uplink) and N6 (IPv4 downlink) ingress streams, tagging each beat with its interface.
module parser_port_arbiter #(
    parameter int         DATA_W      = 64,
    parameter int         KEEP_W      = DATA_W / 8,
    parameter logic [7:0] N3_IFACE_ID = 8'd0,
    parameter logic [7:0] N6_IFACE_ID = 8'd1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_n3_en,
    input  logic              cfg_n6_en,
    input  logic              n3_valid,
    output logic              n3_ready,
    input  logic [DATA_W-1:0] n3_data,
    input  logic [KEEP_W-1:0] n3_keep,
    input  logic              n3_last,
    input  logic              n6_valid,
    output logic              n6_ready,
    input  logic [DATA_W-1:0] n6_data,
    input  logic [KEEP_W-1:0] n6_keep,
    input  logic              n6_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic              out_last,
    output logic [7:0]        out_iface,
    output logic              busy,
    output logic [31:0]       n3_pkt_cnt,
    output logic [31:0]       n6_pkt_cnt,
    output logic [1:0]        arb_state
);

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_N3   = 2'd1;
    localparam logic [1:0] ARB_N6   = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        rr_pref;      // 0 = N3 preferred, 1 = N6 preferred
    logic        out_free;
    logic        elig_n3;
    logic        elig_n6;
    logic        take_n3;
    logic        take_n6;
    logic [31:0] n3_cnt;
    logic [31:0] n6_cnt;

    // All streams are valid/ready: a beat transfers on a rising clk edge where valid && ready
    // are both high; ready is only ever raised for the port that currently owns the grant.
    assign out_free = !out_valid || out_ready;
    assign n3_ready = (state == ARB_N3) && out_free;
    assign n6_ready = (state == ARB_N6) && out_free;
    assign take_n3  = n3_valid && n3_ready;
    assign take_n6  = n6_valid && n6_ready;
    assign elig_n3  = n3_valid && cfg_n3_en;
    assign elig_n6  = n6_valid && cfg_n6_en;

    assign busy       = (state != ARB_IDLE);
    assign arb_state  = state;
    assign n3_pkt_cnt = n3_cnt;
    assign n6_pkt_cnt = n6_cnt;

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (elig_n3 && elig_n6) begin
                    state_nxt = rr_pref ? ARB_N6 : ARB_N3;
                end else if (elig_n3) begin
                    state_nxt = ARB_N3;
                end else if (elig_n6) begin
                    state_nxt = ARB_N6;
                end
            end
            ARB_N3: begin
                if (take_n3 && n3_last) begin
                    state_nxt = ARB_IDLE;
                end
            end
            ARB_N6: begin
                if (take_n6 && n6_last) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ARB_IDLE;
            rr_pref <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take_n3 && n3_last) begin
                rr_pref <= 1'b1;
            end else if (take_n6 && n6_last) begin
                rr_pref <= 1'b0;
            end
        end
    end

    // Single output register: a load and a drain in the same cycle keep full throughput.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            out_iface <= 8'd0;
        end else if (take_n3) begin
            out_valid <= 1'b1;
            out_data  <= n3_data;
            out_keep  <= n3_keep;
            out_last  <= n3_last;
            out_iface <= N3_IFACE_ID;
        end else if (take_n6) begin
            out_valid <= 1'b1;
            out_data  <= n6_data;
            out_keep  <= n6_keep;
            out_last  <= n6_last;
            out_iface <= N6_IFACE_ID;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Packets are counted at input acceptance of the last beat and wrap freely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n3_cnt <= 32'd0;
            n6_cnt <= 32'd0;
        end else begin
            if (take_n3 && n3_last) begin
                n3_cnt <= n3_cnt + 32'd1;
            end
            if (take_n6 && n6_last) begin
                n6_cnt <= n6_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_parser_port_arbiter.sv
// Bench for parser_port_arbiter: randomized per-port packet traffic scored against
// per-port expected queues, plus directed round-robin, stall, enable, wrap and reset steps.
module tb_parser_port_arbiter;

    localparam int DATA_W = 64;
    localparam int KEEP_W = 8;
    localparam int BW     = DATA_W + KEEP_W + 1;

    typedef logic [BW-1:0] beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_n3_en;
    logic              cfg_n6_en;
    logic              n3_valid = 1'b0;
    logic              n3_ready;
    logic [DATA_W-1:0] n3_data = '0;
    logic [KEEP_W-1:0] n3_keep = '0;
    logic              n3_last = 1'b0;
    logic              n6_valid = 1'b0;
    logic              n6_ready;
    logic [DATA_W-1:0] n6_data = '0;
    logic [KEEP_W-1:0] n6_keep = '0;
    logic              n6_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [KEEP_W-1:0] out_keep;
    logic              out_last;
    logic [7:0]        out_iface;
    logic              busy;
    logic [31:0]       n3_pkt_cnt;
    logic [31:0]       n6_pkt_cnt;
    logic [1:0]        arb_state;

    int checks   = 0;
    int failures = 0;

    beat_t      in3_q[$];
    beat_t      in6_q[$];
    beat_t      exp3_q[$];
    beat_t      exp6_q[$];
    logic [7:0] order_q[$];

    int          gap_pct   = 0;
    int          ready_pct = 100;
    bit          hold_low  = 1'b0;
    logic [31:0] cnt3_base = 32'd0;
    logic [31:0] cnt6_base = 32'd0;

    logic [31:0] acc3_pkts  = 32'd0;
    logic [31:0] acc6_pkts  = 32'd0;
    int          acc3_beats = 0;
    int          acc6_beats = 0;
    int          out_beats  = 0;
    bit          have_acc   = 1'b0;
    beat_t       acc_beat;
    logic [7:0]  acc_iface;
    bit          stall_prev = 1'b0;
    logic [81:0] prev_out;
    bit          in_pkt     = 1'b0;
    logic [7:0]  cur_iface;

    parser_port_arbiter #(
        .DATA_W(DATA_W), .KEEP_W(KEEP_W), .N3_IFACE_ID(8'd0), .N6_IFACE_ID(8'd1)
    ) dut (
        .clk(clk), .rst(rst), .cfg_n3_en(cfg_n3_en), .cfg_n6_en(cfg_n6_en),
        .n3_valid(n3_valid), .n3_ready(n3_ready), .n3_data(n3_data), .n3_keep(n3_keep),
        .n3_last(n3_last),
        .n6_valid(n6_valid), .n6_ready(n6_ready), .n6_data(n6_data), .n6_keep(n6_keep),
        .n6_last(n6_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_keep(out_keep), .out_last(out_last), .out_iface(out_iface), .busy(busy),
        .n3_pkt_cnt(n3_pkt_cnt), .n6_pkt_cnt(n6_pkt_cnt), .arb_state(arb_state)
    );

    // Clock/reset: posedge at 10+20k, inputs change on negedge, DUT sampled 4 units later.
    always #10 clk = ~clk;

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #6;
    endtask

    task automatic push_pkt(input int port, input int len);
        beat_t             b;
        logic              lst;
        logic [KEEP_W-1:0] k;
        logic [DATA_W-1:0] d;
        for (int i = 0; i < len; i++) begin
            lst = (i == len - 1);
            k   = KEEP_W'($urandom);
            d   = {$urandom, $urandom};
            b   = {lst, k, d};
            if (port == 0) begin
                in3_q.push_back(b);
                exp3_q.push_back(b);
            end else begin
                in6_q.push_back(b);
                exp6_q.push_back(b);
            end
        end
    endtask

    // mode 0: everything drained; mode 1: only N6 drained, N3 must stay blocked meanwhile.
    task automatic wait_done(input int mode, input int budget, input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            if (mode == 1) begin
                check("n3_blocked_while_disabled", n3_ready, 1'b0);
                done = (in6_q.size() == 0) && (exp6_q.size() == 0);
            end else begin
                done = (in3_q.size() == 0) && (in6_q.size() == 0) &&
                       (exp3_q.size() == 0) && (exp6_q.size() == 0) && !out_valid;
            end
        end
        check(tag, done, 1'b1);
    endtask

    // Driver tasks as free-running processes: present the queue head, pop on handshake.
    always begin
        @(negedge clk);
        if (!rst && in3_q.size() != 0 && $urandom_range(1, 100) > gap_pct) begin
            n3_valid = 1'b1;
            {n3_last, n3_keep, n3_data} = in3_q[0];
        end else begin
            n3_valid = 1'b0;
            {n3_last, n3_keep, n3_data} = '0;
        end
        #4;
        if (!rst && n3_valid && n3_ready) void'(in3_q.pop_front());
    end

    always begin
        @(negedge clk);
        if (!rst && in6_q.size() != 0 && $urandom_range(1, 100) > gap_pct) begin
            n6_valid = 1'b1;
            {n6_last, n6_keep, n6_data} = in6_q[0];
        end else begin
            n6_valid = 1'b0;
            {n6_last, n6_keep, n6_data} = '0;
        end
        #4;
        if (!rst && n6_valid && n6_ready) void'(in6_q.pop_front());
    end

    always begin
        @(negedge clk);
        out_ready = hold_low ? 1'b0 : ($urandom_range(1, 100) <= ready_pct);
    end

    // Scoreboard / monitor
    always begin
        logic [31:0] e3;
        logic [31:0] e6;
        beat_t       obs;
        @(negedge clk);
        #4;
        if (rst) begin
            have_acc   = 1'b0;
            stall_prev = 1'b0;
            in_pkt     = 1'b0;
            acc3_pkts  = 32'd0;
            acc6_pkts  = 32'd0;
        end else begin
            e3 = cnt3_base + acc3_pkts;
            e6 = cnt6_base + acc6_pkts;
            check("n3_pkt_cnt", n3_pkt_cnt, e3);
            check("n6_pkt_cnt", n6_pkt_cnt, e6);
            check("ready_exclusive", n3_ready && n6_ready, 1'b0);
            if (have_acc) begin
                check("latency_valid", out_valid, 1'b1);
                check("latency_beat", {out_last, out_keep, out_data}, acc_beat);
                check("latency_iface", out_iface, acc_iface);
            end
            if (stall_prev) begin
                check("stall_hold", {out_valid, out_iface, out_last, out_keep, out_data}, prev_out);
            end
            if (out_valid && out_ready) begin
                obs = {out_last, out_keep, out_data};
                out_beats++;
                check("out_iface_known", out_iface <= 8'd1, 1'b1);
                if (out_iface == 8'd0) begin
                    check("n3_beat_expected", exp3_q.size() != 0, 1'b1);
                    if (exp3_q.size() != 0) check("n3_beat", obs, exp3_q.pop_front());
                end else if (out_iface == 8'd1) begin
                    check("n6_beat_expected", exp6_q.size() != 0, 1'b1);
                    if (exp6_q.size() != 0) check("n6_beat", obs, exp6_q.pop_front());
                end
                if (in_pkt) check("pkt_iface_lock", out_iface, cur_iface);
                cur_iface = out_iface;
                in_pkt    = !out_last;
                if (out_last) order_q.push_back(out_iface);
            end
            have_acc = 1'b0;
            if (n3_valid && n3_ready) begin
                have_acc  = 1'b1;
                acc_beat  = {n3_last, n3_keep, n3_data};
                acc_iface = 8'd0;
                acc3_beats++;
                if (n3_last) acc3_pkts = acc3_pkts + 32'd1;
            end
            if (n6_valid && n6_ready) begin
                have_acc  = 1'b1;
                acc_beat  = {n6_last, n6_keep, n6_data};
                acc_iface = 8'd1;
                acc6_beats++;
                if (n6_last) acc6_pkts = acc6_pkts + 32'd1;
            end
            stall_prev = out_valid && !out_ready;
            prev_out   = {out_valid, out_iface, out_last, out_keep, out_data};
        end
    end

    initial begin
        logic [7:0] rr_exp [4];
        int         base;
        bit         seen;
        logic [31:0] n6_before;

        rst       = 1'b1;
        cfg_n3_en = 1'b1;
        cfg_n6_en = 1'b1;
        repeat (3) step();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_out_keep", out_keep, '0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_iface", out_iface, 8'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_state", arb_state, 2'd0);
        check("rst_ready", {n3_ready, n6_ready}, 2'b00);
        check("rst_cnt", {n3_pkt_cnt, n6_pkt_cnt}, 64'd0);
        rst = 1'b0;
        step();

        // Round-robin with both ports continuously loaded: N3 first after reset, then alternate.
        push_pkt(0, 2); push_pkt(0, 2);
        push_pkt(1, 2); push_pkt(1, 2);
        wait_done(0, 200, "rr_drain");
        rr_exp = '{8'd0, 8'd1, 8'd0, 8'd1};
        check("rr_order_len", order_q.size(), 4);
        for (int i = 0; i < 4 && i < order_q.size(); i++) check("rr_order", order_q[i], rr_exp[i]);
        check("rr_n3_cnt", n3_pkt_cnt, 32'd2);
        check("rr_n6_cnt", n6_pkt_cnt, 32'd2);

        // 3-beat N3 packet; busy falls one cycle after the last input beat.
        push_pkt(0, 3);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            step();
            seen = n3_valid && n3_ready && n3_last;
        end
        check("last_beat_seen", seen, 1'b1);
        check("busy_on_last", busy, 1'b1);
        step();
        check("busy_after_last", busy, 1'b0);
        wait_done(0, 100, "three_beat_drain");
        check("three_beat_cnt", n3_pkt_cnt, 32'd3);
        check("three_beat_order", order_q[order_q.size()-1], 8'd0);

        // Output stall for 5 cycles mid-packet.
        push_pkt(0, 6);
        base = out_beats;
        for (int i = 0; i < 50 && out_beats < base + 2; i++) step();
        hold_low = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_n3_ready", n3_ready, 1'b0);
            check("stall_out_valid", out_valid, 1'b1);
        end
        hold_low = 1'b0;
        wait_done(0, 100, "stall_drain");

        // N3 disabled with traffic waiting; N6 is served, N3 never granted.
        cfg_n3_en = 1'b0;
        push_pkt(0, 2);
        push_pkt(1, 3); push_pkt(1, 3);
        wait_done(1, 200, "n6_served_while_n3_disabled");
        check("n3_untouched", in3_q.size(), 2);
        check("n3_cnt_unchanged", n3_pkt_cnt, 32'd4);
        // Dropping the N6 enable mid-packet lets that packet finish.
        n6_before = n6_pkt_cnt;
        push_pkt(1, 4);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            step();
            seen = n6_valid && n6_ready;
        end
        cfg_n6_en = 1'b0;
        wait_done(1, 200, "n6_completes_after_disable");
        check("n6_cnt_after_disable", n6_pkt_cnt, n6_before + 32'd1);
        cfg_n3_en = 1'b1;
        wait_done(0, 200, "n3_after_reenable");
        cfg_n6_en = 1'b1;

        // Random traffic with gaps, backpressure and single-beat packets.
        gap_pct   = 30;
        ready_pct = 60;
        for (int i = 0; i < 24; i++) push_pkt($urandom_range(0, 1), $urandom_range(1, 5));
        wait_done(0, 4000, "random_drain");
        gap_pct   = 0;
        ready_pct = 100;

        // Counter wrap on N6.
        step();
        force dut.n6_cnt = 32'hFFFF_FFFF;
        cnt6_base = 32'hFFFF_FFFF - acc6_pkts;
        step();
        release dut.n6_cnt;
        push_pkt(1, 1);
        wait_done(0, 50, "wrap_drain");
        check("n6_cnt_wrap", n6_pkt_cnt, 32'd0);

        // Reset during beat 2 of a 4-beat N3 packet.
        base = acc3_beats;
        push_pkt(0, 4);
        for (int i = 0; i < 50 && acc3_beats < base + 2; i++) step();
        check("reset_point_reached", acc3_beats >= base + 2, 1'b1);
        rst = 1'b1;
        in3_q.delete(); in6_q.delete(); exp3_q.delete(); exp6_q.delete(); order_q.delete();
        cnt3_base = 32'd0;
        cnt6_base = 32'd0;
        #1;
        check("async_rst_out_valid", out_valid, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_cnt", {n3_pkt_cnt, n6_pkt_cnt}, 64'd0);
        step();
        check("rst_held_state", arb_state, 2'd0);
        check("rst_held_out_valid", out_valid, 1'b0);
        rst = 1'b0;
        push_pkt(1, 1);
        push_pkt(0, 1);
        wait_done(0, 50, "post_rst_both");
        check("post_rst_order_len", order_q.size(), 2);
        if (order_q.size() == 2) begin
            check("post_rst_first_n3", order_q[0], 8'd0);
            check("post_rst_second_n6", order_q[1], 8'd1);
        end
        push_pkt(1, 2);
        wait_done(0, 50, "post_rst_n6_alone");
        check("n6_alone_granted", order_q[order_q.size()-1], 8'd1);
        check("final_cnt", {n3_pkt_cnt, n6_pkt_cnt}, {32'd1, 32'd2});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/parser_port_arbiter.md
Name: parser_port_arbiter

Overview:
Packet-granular round-robin arbiter that shares one header-parser datapath between the N3 (GTP-U uplink) and N6 (plain IPv4 downlink) ingress streams. It locks onto one port for a whole packet and forwards that packet's beats through a single registered output stage. Each forwarded beat is tagged with the interface it came from, which feeds the PHS incoming_interface field and selects N3_STATES or N6_STATES parsing downstream. The block also keeps per-port accepted-packet counters and per-port enable configuration.

Parameters:
DATA_W, 64, beat data width in bits; must be a multiple of 8.
KEEP_W, DATA_W/8, byte-enable width.
N3_IFACE_ID, 8'd0, value driven on out_iface for N3 packets.
N6_IFACE_ID, 8'd1, value driven on out_iface for N6 packets.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cfg_n3_en  in  1  N3 port enable; sampled only at packet boundaries
cfg_n6_en  in  1  N6 port enable; sampled only at packet boundaries
n3_valid  in  1  N3 beat valid
n3_ready  out  1  N3 beat accepted when n3_valid && n3_ready
n3_data  in  DATA_W  N3 beat data
n3_keep  in  KEEP_W  N3 byte enables
n3_last  in  1  N3 end of packet
n6_valid / n6_ready / n6_data / n6_keep / n6_last  same as the N3 set, for the N6 port
out_valid  out  1  beat presented to the parser
out_ready  in  1  parser accepts the beat
out_data  out  DATA_W  forwarded data
out_keep  out  KEEP_W  forwarded byte enables
out_last  out  1  forwarded end of packet
out_iface  out  8  N3_IFACE_ID or N6_IFACE_ID
busy  out  1  a packet is in progress (state is not ARB_IDLE)
n3_pkt_cnt  out  32  count of N3 packets whose last beat was accepted
n6_pkt_cnt  out  32  count of N6 packets whose last beat was accepted

Behaviour:
- Reset (asynchronous, takes effect immediately): state=ARB_IDLE, rr_pref=N3, out_valid=0. out_data, out_keep, out_last, out_iface, both counters and both readies are 0. busy=0.
- States:
  - ARB_IDLE: no grant. Eligible port = valid && cfg_en.
    - Both ports eligible -> grant rr_pref.
    - One port eligible -> grant that port.
    - Neither -> stay in ARB_IDLE.
    - The grant decision takes one cycle; no beat is accepted in ARB_IDLE.
  - ARB_N3 / ARB_N6: the granted port is locked.
    - x_ready = (!out_valid || out_ready). The non-granted port's ready is 0.
    - An accepted beat with last=1 returns to ARB_IDLE next cycle and sets rr_pref to the other port.
- Output stage is a single register.
  - An accepted input beat loads out_* next cycle with out_valid=1; latency is 1 cycle.
  - out_valid clears when out_ready=1 and no new beat is loaded. Simultaneous drain and load in the same cycle gives full throughput.
  - out_* hold stable while out_valid && !out_ready.
- Minimum inter-packet gap at the input is 1 cycle (the ARB_IDLE grant cycle). The output may show a 1-cycle bubble between packets.
- Enables:
  - Deasserting cfg_x_en mid-packet does not abort the packet; the lock holds until last.
  - A disabled port's ready stays 0 outside its grant.
- Counters increment on acceptance of the input beat with last=1, not on output. They wrap at 2^32-1 -> 0 with no saturation.
- Single-beat packet (first beat has last=1): ARB_x -> ARB_IDLE after 1 accepted beat. rr_pref still toggles.
- Input valid dropping mid-packet: the grant is held indefinitely. There is no timeout.
- Reset asserted mid-packet: the in-flight beat in the output register is discarded (out_valid=0). Downstream must treat reset as a flush.

Test Plan:
- Both ports enabled, N3 sends a 3-beat packet, N6 idle -> out sees 3 beats with out_iface=0 and out_last on beat 3; n3_pkt_cnt=1; busy deasserts 1 cycle after the last input beat.
- Both ports present continuous 2-beat packets, out_ready=1 -> grant order N3,N6,N3,N6; after 4 packets n3_pkt_cnt=2 and n6_pkt_cnt=2; n6_ready=0 throughout every N3 grant.
- out_ready held 0 for 5 cycles mid-packet -> out_* stable and n3_ready=0 for those cycles; no beat lost or duplicated; out_data sequence matches the input.
- cfg_n3_en=0 with n3_valid=1 -> N3 never granted, n3_ready=0; N6 traffic is served. Dropping cfg_n6_en during an N6 packet -> that packet completes.
- Force n6_pkt_cnt to 32'hFFFFFFFF (via backdoor), send one N6 packet -> counter reads 0.
- Assert rst during beat 2 of a 4-beat packet -> out_valid=0, state ARB_IDLE, counters 0 on the next edge; a fresh N6 packet after release is granted first only if N3 is idle (rr_pref=N3).
